// File: rtl/segway_pkg.sv
// Shared types and constants for the segway control blocks.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEER
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WEIGHT_DEF = 12'h200;
    localparam int unsigned TMR_W_FULL           = 26;
    localparam int unsigned TMR_W_FAST           = 15;

endpackage

// File: rtl/steer_en_sm_if.sv
// Load-cell inputs and steering/rider status outputs of the steering enable block.
interface steer_en_sm_if;

    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    modport master (
        output lft_ld,
        output rght_ld,
        input  en_steer,
        input  rider_off
    );

    modport slave (
        input  lft_ld,
        input  rght_ld,
        output en_steer,
        output rider_off
    );

endinterface

// File: rtl/steer_tmr.sv
// Settle timer: N-bit up-counter with synchronous clear; full when all bits are set.
module steer_tmr #(
    parameter int unsigned N = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic full
);

    logic [N-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full = &cnt_q;

endmodule

// File: rtl/steer_en_sm.sv
// Rider-presence and steering-enable controller: steering is granted after the rider
// has stood evenly for 2^N cycles and withdrawn on gross imbalance or step-off.
module steer_en_sm
    import segway_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WEIGHT = MIN_RIDER_WEIGHT_DEF,
    parameter bit          FAST_SIM         = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    steer_en_sm_if.slave  bus
);

    localparam int unsigned TMR_W = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;

    steer_state_t state_q, state_d;
    logic         en_steer_q, en_steer_d;
    logic         rider_off_q, rider_off_d;
    logic         tmr_clr, tmr_inc, tmr_full;

    logic [12:0]  sum, diff;
    logic         present, gt_1_4, gt_15_16;

    // All comparisons are carried at 13 bits so the sum never overflows.
    assign sum      = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    assign diff     = (bus.lft_ld >= bus.rght_ld) ? {1'b0, bus.lft_ld - bus.rght_ld}
                                                  : {1'b0, bus.rght_ld - bus.lft_ld};
    assign present  = (sum >= {1'b0, MIN_RIDER_WEIGHT});
    assign gt_1_4   = (diff > (sum >> 2));
    assign gt_15_16 = (diff > (sum - (sum >> 4)));

    steer_tmr #(
        .N (TMR_W)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .full  (tmr_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (present && !gt_1_4) begin
                    state_d = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            WAIT: begin
                if (!present) begin
                    state_d = IDLE;
                end else if (gt_1_4) begin
                    tmr_clr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            STEER: begin
                // Step-off takes priority over imbalance.
                if (!present) begin
                    state_d = IDLE;
                end else if (gt_15_16) begin
                    state_d = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_steer_d  = (state_d == STEER);
        rider_off_d = !present;
    end

    assign bus.en_steer  = en_steer_q;
    assign bus.rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en_sm.sv
// Scoreboard bench for steer_en_sm (FAST_SIM): a rule-level model queues the expected
// outputs for every driven cycle and a monitor compares them after each clock edge.
module tb_steer_en_sm;
    import segway_pkg::*;

    localparam int SETTLE = 1 << TMR_W_FAST;
    localparam int MIN_W  = 'h200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    steer_en_sm_if bus_if ();

    steer_en_sm #(
        .MIN_RIDER_WEIGHT (12'h200),
        .FAST_SIM         (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic en;
        logic off;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Rider model: m_wait = standing evenly and settling, m_cnt = balanced cycles so far.
    bit   m_steer = 1'b0;
    bit   m_wait  = 1'b0;
    int   m_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endtask

    task automatic model_step(input int l, input int r, output exp_t e);
        int s, d;
        s = l + r;
        d = (l > r) ? l - r : r - l;
        if (s < MIN_W) begin
            m_steer = 1'b0;
            m_wait  = 1'b0;
        end else if (m_steer) begin
            if (d > s - s / 16) begin
                m_steer = 1'b0;
                m_wait  = 1'b1;
                m_cnt   = 0;
            end
        end else if (!m_wait) begin
            if (d <= s / 4) begin
                m_wait = 1'b1;
                m_cnt  = 0;
            end
        end else if (d > s / 4) begin
            m_cnt = 0;
        end else if (m_cnt == SETTLE - 1) begin
            m_steer = 1'b1;
            m_wait  = 1'b0;
        end else begin
            m_cnt++;
        end
        e.en  = m_steer;
        e.off = (s < MIN_W);
    endtask

    // Hold the loads for n cycles; returns just after the last edge's outputs settled.
    task automatic drive(input int l, input int r, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.lft_ld  = 12'(l);
            bus_if.rght_ld = 12'(r);
            model_step(l, r, e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("en_steer", {31'b0, bus_if.en_steer}, {31'b0, e.en});
            check("rider_off", {31'b0, bus_if.rider_off}, {31'b0, e.off});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int l, r, rise;
        bus_if.lft_ld  = '0;
        bus_if.rght_ld = '0;
        #23;
        check("reset en_steer", {31'b0, bus_if.en_steer}, 32'd0);
        check("reset rider_off", {31'b0, bus_if.rider_off}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Too light to count as a rider.
        drive('h100, 'h050, 1000);

        // Random loads around the presence and balance thresholds.
        for (int k = 0; k < 150; k++) begin
            drive($urandom_range('h400, 0), $urandom_range('h400, 0), $urandom_range(12, 1));
        end
        drive(0, 0, 4);

        // Even rider from IDLE: enable on edge SETTLE+1.
        drive('h110, 'h100, SETTLE);
        check("en_steer at edge 2^N", {31'b0, bus_if.en_steer}, 32'd0);
        check("rider_off while settling", {31'b0, bus_if.rider_off}, 32'd0);
        drive('h110, 'h100, 1);
        check("en_steer at edge 2^N+1", {31'b0, bus_if.en_steer}, 32'd1);

        // Gross imbalance in STEER drops steering on the next edge.
        drive('h200, 'h004, 1);
        check("imbalance drops en_steer", {31'b0, bus_if.en_steer}, 32'd0);
        check("imbalance keeps rider", {31'b0, bus_if.rider_off}, 32'd0);

        // Settling interrupted by a 1/4 imbalance, then restarted with jittery even loads.
        drive('h110, 'h100, 200);
        drive('h200, 'h080, 3);
        rise = 0;
        for (int i = 1; i <= SETTLE + 8; i++) begin
            if (i == 1) begin
                l = 'h140;
                r = 'h0C0;
            end else begin
                l = $urandom_range('h7FF, 'h140);
                r = $urandom_range(l, (3 * l + 4) / 5);
                if ($urandom_range(1, 0) == 1) begin
                    int t;
                    t = l;
                    l = r;
                    r = t;
                end
            end
            drive(l, r, 1);
            if (bus_if.en_steer === 1'b1) begin
                rise = i;
                break;
            end
        end
        check("settle cycles after restart", rise, SETTLE);

        // Exactly 15/16 imbalance keeps steering.
        drive('h3E0, 'h020, 20);
        check("15/16 boundary keeps en_steer", {31'b0, bus_if.en_steer}, 32'd1);

        // Step-off just below the weight threshold.
        drive('h180, 'h07F, 1);
        check("step-off en_steer", {31'b0, bus_if.en_steer}, 32'd0);
        check("step-off rider_off", {31'b0, bus_if.rider_off}, 32'd1);

        // Exactly the minimum weight counts as present.
        drive('h100, 'h100, 300);
        check("min weight present", {31'b0, bus_if.rider_off}, 32'd0);

        // Asynchronous reset while settling, away from any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset rider_off", {31'b0, bus_if.rider_off}, 32'd1);
        check("async reset en_steer", {31'b0, bus_if.en_steer}, 32'd0);
        m_steer = 1'b0;
        m_wait  = 1'b0;
        m_cnt   = 0;
        repeat (2) @(posedge clk);
        check("reset held rider_off", {31'b0, bus_if.rider_off}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive('h100, 'h100, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
